// File: rtl/counter_updown_modulo.sv
// -----------------------------------------------------------------------------
// counter_updown_modulo
//
// Up/down step counter with a terminal value programmable at run time. It
// sequences multi-cycle datapaths (sequential multiply/divide, shift loops)
// whose iteration count changes from one operation to the next.
//
// The counter either wraps or saturates (holds) at the terminal value. It has
// a synchronous clear, a synchronous parallel load, combinational
// start-of-sequence and terminal flags, and a registered one-cycle pulse that
// fires after each enabled step taken at the terminal value.
//
// Optional feature (compile-time macro COUNTER_WRAP_CNT_EN):
//   When the macro is defined, wrap_cnt counts the wrap events and saturates at
//   2**WW-1. When it is undefined, wrap_cnt is tied to 0 and no register is
//   built for it.
//
// Parameters:
//   DW       counter width in bits
//   DEF_MAX  terminal value loaded into max_count_q at reset
//   WW       width of the wrap-event counter (optional feature only)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   enable    in   count-step enable
//   clear     in   synchronous clear: count -> 0, done -> 0, wrap_cnt -> 0
//   load      in   synchronous parallel load of load_val (clamped to terminal)
//   load_val  in   value to load
//   max_wr    in   strobe: capture max_in as the new terminal value
//   max_in    in   new terminal value
//   dir       in   0 = count up, 1 = count down
//   sat       in   0 = wrap at terminal, 1 = hold at terminal
//   count     out  current count
//   first     out  start of sequence while enabled (combinational)
//   overflow  out  count is at the terminal value (combinational)
//   done      out  one-cycle pulse after an enabled step taken at terminal
//   wrap_cnt  out  number of wrap events (0 unless COUNTER_WRAP_CNT_EN)
// -----------------------------------------------------------------------------
module counter_updown_modulo #(
    parameter int DW      = 4,
    parameter int DEF_MAX = 2**DW - 1,
    parameter int WW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          max_wr,
    input  logic [DW-1:0] max_in,
    input  logic          dir,
    input  logic          sat,
    output logic [DW-1:0] count,
    output logic          first,
    output logic          overflow,
    output logic          done,
    output logic [WW-1:0] wrap_cnt
);

    localparam logic [DW-1:0] DEF_MAX_V = DEF_MAX[DW-1:0];
    localparam logic [DW-1:0] ONE       = DW'(1);

    logic [DW-1:0] count_r;
    logic [DW-1:0] max_count_q;
    logic          done_r;

    logic          term;        // terminal condition T
    logic          step_taken;  // an enabled step that is not overridden
    logic [DW-1:0] step_next;   // count after an enabled step
    logic [DW-1:0] load_next;   // load_val clamped to the current terminal

    // Counting up, the terminal test is ">=" rather than "==". This way, a
    // terminal value lowered below the running count takes effect at once.
    assign term       = dir ? (count_r == '0) : (count_r >= max_count_q);
    assign step_taken = enable & ~clear & ~load;
    assign load_next  = (load_val > max_count_q) ? max_count_q : load_val;

    // NOTE: every output of a combinational block gets a default value first.
    // Any path that leaves it unassigned would infer a latch.
    always_comb begin
        step_next = count_r;
        if (!term) begin
            step_next = dir ? (count_r - ONE) : (count_r + ONE);
        end else if (!sat) begin
            step_next = dir ? max_count_q : '0;
        end
    end

    // The terminal register always accepts a write, whatever the count is
    // doing. A load in the same cycle still clamps against the old value.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge, with no order-of-evaluation
    // races between blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_count_q <= DEF_MAX_V;
        end else if (max_wr) begin
            max_count_q <= max_in;
        end
    end

    // Priority: clear > load > enable. A clear or load suppresses the step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_next;
        end else if (enable) begin
            count_r <= step_next;
        end
    end

    // done covers both wrap and hold events at the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= step_taken & term;
        end
    end

`ifdef COUNTER_WRAP_CNT_EN
    logic [WW-1:0] wrap_cnt_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_cnt_r <= '0;
        end else if (clear) begin
            wrap_cnt_r <= '0;
        end else if (step_taken && term && !sat && (wrap_cnt_r != '1)) begin
            wrap_cnt_r <= wrap_cnt_r + WW'(1);
        end
    end

    assign wrap_cnt = wrap_cnt_r;
`else
    assign wrap_cnt = '0;
`endif

    assign count    = count_r;
    assign overflow = term;
    assign done     = done_r;
    assign first    = enable & (dir ? (count_r == max_count_q) : (count_r == '0));

endmodule

// File: tb/tb_counter_updown_modulo.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_modulo
//
// Self-checking bench for counter_updown_modulo (DW=4, default terminal 15,
// WW=8). A behavioural model, written with integer arithmetic, tracks count,
// terminal value, done and wrap count. A compare process checks every DUT
// output against the model on each falling clock edge. Directed sequences pin
// the model with literal expectations. A randomized phase then drives all
// controls, including occasional asynchronous resets. Build with
// +define+COUNTER_WRAP_CNT_EN to exercise the wrap counter.
// -----------------------------------------------------------------------------
module tb_counter_updown_modulo;

    localparam int DW      = 4;
    localparam int WW      = 8;
    localparam int DEF_MAX = 15;
    localparam int WRAP_MX = 255;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          enable   = 1'b1;
    logic          clear    = 1'b0;
    logic          load     = 1'b0;
    logic [DW-1:0] load_val = '0;
    logic          max_wr   = 1'b0;
    logic [DW-1:0] max_in   = '0;
    logic          dir      = 1'b0;
    logic          sat      = 1'b0;
    logic [DW-1:0] count;
    logic          first;
    logic          overflow;
    logic          done;
    logic [WW-1:0] wrap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int m_count = 0;
    int m_max   = DEF_MAX;
    int m_done  = 0;
    int m_wrap  = 0;

    counter_updown_modulo #(.DW(DW), .DEF_MAX(DEF_MAX), .WW(WW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .max_wr   (max_wr),
        .max_in   (max_in),
        .dir      (dir),
        .sat      (sat),
        .count    (count),
        .first    (first),
        .overflow (overflow),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int at_term(input int c, input int m, input logic d);
        return d ? int'(c == 0) : int'(c >= m);
    endfunction

    function automatic int exp_wrap_cnt();
`ifdef COUNTER_WRAP_CNT_EN
        return m_wrap;
`else
        return 0;
`endif
    endfunction

    // Reference model: updated on each active edge from pre-edge inputs.
    always @(posedge clk or negedge rst) begin
        int t;
        int nxt_max;
        if (!rst) begin
            m_count = 0;
            m_max   = DEF_MAX;
            m_done  = 0;
            m_wrap  = 0;
        end else begin
            t       = at_term(m_count, m_max, dir);
            nxt_max = max_wr ? int'(max_in) : m_max;
            if (clear) begin
                m_count = 0;
                m_done  = 0;
                m_wrap  = 0;
            end else if (load) begin
                m_count = (int'(load_val) > m_max) ? m_max : int'(load_val);
                m_done  = 0;
            end else if (enable) begin
                if (t == 0)   m_count = dir ? m_count - 1 : m_count + 1;
                else if (!sat) m_count = dir ? m_max : 0;
                m_done = t;
                if (t != 0 && !sat && m_wrap < WRAP_MX) m_wrap++;
            end else begin
                m_done = 0;
            end
            m_max = nxt_max;
        end
    end

    // Compare process: every output, every cycle, mid-period.
    always @(negedge clk) begin
        check("cmp_count",    int'(count),    m_count);
        check("cmp_overflow", int'(overflow), at_term(m_count, m_max, dir));
        check("cmp_first",    int'(first),
              int'(enable && (dir ? (m_count == m_max) : (m_count == 0))));
        check("cmp_done",     int'(done),     m_done);
        check("cmp_wrap_cnt", int'(wrap_cnt), exp_wrap_cnt());
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset held with enable=1 for three cycles.
        repeat (3) tick();
        settle();
        check("rst_count",    int'(count),    0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_done",     int'(done),     0);
        rst = 1'b1;

        // Default terminal 15, counting up and wrapping.
        for (int i = 0; i < 16; i++) begin
            settle();
            check("up15_count",    int'(count),    i);
            check("up15_overflow", int'(overflow), int'(i == 15));
            tick();
        end
        settle();
        check("up15_wrap_count", int'(count), 0);
        check("up15_wrap_done",  int'(done),  1);
        tick();
        settle();
        check("up15_done_pulse", int'(done),  0);
        check("up15_count_1",    int'(count), 1);

        // Programmed terminal 5, up, wrap.
        clear = 1'b1; max_wr = 1'b1; max_in = 4'd5;
        tick();
        clear = 1'b0; max_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            settle();
            check("up5_count",    int'(count),    i % 6);
            check("up5_overflow", int'(overflow), int'(i % 6 == 5));
            check("up5_first",    int'(first),    int'(i % 6 == 0));
            check("up5_done",     int'(done),     int'(i > 0 && i % 6 == 0));
            tick();
        end

        // Down and saturate from a loaded 3.
        dir = 1'b1; sat = 1'b1; load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("dn_count",    int'(count),    (3 - i < 0) ? 0 : 3 - i);
            check("dn_overflow", int'(overflow), int'(i >= 3));
            check("dn_done",     int'(done),     int'(i >= 4));
            tick();
        end

        // Load clamp, then clear beats load.
        dir = 1'b0; sat = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        settle();
        check("clamp_count",    int'(count),    5);
        check("clamp_overflow", int'(overflow), 1);
        tick();
        settle();
        check("clamp_wrap_count", int'(count), 0);
        check("clamp_wrap_done",  int'(done),  1);
        clear = 1'b1; load = 1'b1; load_val = 4'd2;
        tick();
        clear = 1'b0; load = 1'b0;
        settle();
        check("clr_ld_count", int'(count), 0);
        check("clr_ld_done",  int'(done),  0);

        // Terminal value lowered below the running count.
        enable = 1'b0; clear = 1'b1; max_wr = 1'b1; max_in = 4'd10;
        tick();
        clear = 1'b0; max_wr = 1'b0; enable = 1'b1;
        repeat (7) tick();
        settle();
        check("low_count7", int'(count), 7);
        enable = 1'b0; max_wr = 1'b1; max_in = 4'd4;
        tick();
        max_wr = 1'b0;
        settle();
        check("low_overflow", int'(overflow), 1);
        check("low_hold7",    int'(count),    7);
        enable = 1'b1;
        tick();
        settle();
        check("low_wrap_count", int'(count), 0);
        check("low_wrap_done",  int'(done),  1);
        enable = 1'b0; max_wr = 1'b1; max_in = 4'd0;
        tick();
        max_wr = 1'b0; enable = 1'b1;
        settle();
        check("max0_count",    int'(count),    0);
        check("max0_first",    int'(first),    1);
        check("max0_overflow", int'(overflow), 1);
        tick();
        settle();
        check("max0_stay",     int'(count),    0);
        check("max0_done",     int'(done),     1);

        // Wrap counter: terminal 2, nine steps give three wraps.
        enable = 1'b0; clear = 1'b1; max_wr = 1'b1; max_in = 4'd2;
        tick();
        clear = 1'b0; max_wr = 1'b0; enable = 1'b1;
        repeat (9) tick();
        settle();
`ifdef COUNTER_WRAP_CNT_EN
        check("wc_three", int'(wrap_cnt), 3);
`else
        check("wc_zero",  int'(wrap_cnt), 0);
`endif
        check("wc_count", int'(count), 0);
        tick();
        settle();
        check("wc_count1", int'(count), 1);

        // Asynchronous reset between clock edges.
        rst = 1'b0;
        #1;
        check("arst_count",    int'(count),    0);
        check("arst_wrap_cnt", int'(wrap_cnt), 0);
        check("arst_done",     int'(done),     0);
        tick();
        rst = 1'b1;

        // Randomized phase against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst      = ($urandom_range(0, 299) != 0);
            enable   = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = DW'($urandom_range(0, 15));
            max_wr   = ($urandom_range(0, 15) == 0);
            max_in   = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 2))
                                                   : DW'($urandom_range(0, 15));
            dir      = ($urandom_range(0, 31) == 0) ? ~dir : dir;
            sat      = ($urandom_range(0, 15) == 0) ? ~sat : sat;
        end
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
